// File: rtl/regfile_2r1w_pkg.sv
// Shared constants for the 2-read / 1-write register file.
package regfile_2r1w_pkg;

    localparam int          DATA_W   = 32;
    localparam int          ADDR_W   = 5;
    localparam int          NUM_REGS = 2 ** ADDR_W;

    // Architectural zero register: never written, always reads as zero.
    localparam logic [4:0]  REG_ZERO = 5'd0;

endpackage : regfile_2r1w_pkg

// File: rtl/regfile_2r1w_word.sv
// One register-file word: a W-bit flop with synchronous clear and write enable.
module reg_word
    import regfile_2r1w_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    // Next value: load the write data when enabled, otherwise hold.
    always_comb begin
        // NOTE: every path assigns data_d, so no latch is inferred.
        data_d = data_q;
        if (wr_en) begin
            data_d = wr_data;
        end
    end

    // State update; reset wins over any write in the same cycle.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking so every word updates from pre-edge values.
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign rd_data = data_q;

endmodule : reg_word

// File: rtl/regfile_2r1w.sv
// 32 x 32 register file with two combinational read ports, one synchronous
// write port, hardwired-zero register 0 and optional write-to-read bypass.
module regfile_2r1w #(
    parameter int DATA_W = regfile_2r1w_pkg::DATA_W,
    parameter int ADDR_W = regfile_2r1w_pkg::ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB
);

    import regfile_2r1w_pkg::*;

    localparam int                NUM_WORDS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [NUM_WORDS-1:0] word_we;
    logic [DATA_W-1:0]    word_val [NUM_WORDS];
    logic [DATA_W-1:0]    rd_a_raw;
    logic [DATA_W-1:0]    rd_b_raw;
    logic                 byp_a_hit;
    logic                 byp_b_hit;

    // One-hot write decode; the zero register never receives an enable.
    always_comb begin
        word_we = '0;
        for (int k = 1; k < NUM_WORDS; k++) begin
            word_we[k] = ctrl_writeEnable && (ctrl_writeReg == ADDR_W'(k));
        end
    end

    // Storage: word 0 is a constant, the rest are enabled flops.
    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
        if (k == 0) begin : g_zero
            assign word_val[k] = '0;
        end else begin : g_reg
            reg_word #(
                .W (DATA_W)
            ) u_word (
                .clock   (clock),
                .reset   (reset),
                .wr_en   (word_we[k]),
                .wr_data (data_writeReg),
                .rd_data (word_val[k])
            );
        end
    end

    // Read muxes followed by the optional same-cycle forward of write data.
    always_comb begin
        rd_a_raw  = word_val[ctrl_readRegA];
        rd_b_raw  = word_val[ctrl_readRegB];
        byp_a_hit = (BYPASS != 0) && ctrl_writeEnable && !reset &&
                    (ctrl_writeReg != ZERO_ADDR) && (ctrl_writeReg == ctrl_readRegA);
        byp_b_hit = (BYPASS != 0) && ctrl_writeEnable && !reset &&
                    (ctrl_writeReg != ZERO_ADDR) && (ctrl_writeReg == ctrl_readRegB);
        data_readRegA = byp_a_hit ? data_writeReg : rd_a_raw;
        data_readRegB = byp_b_hit ? data_writeReg : rd_b_raw;
    end

endmodule : regfile_2r1w

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: one bypassing and one non-bypassing instance share
// the same stimulus; an array model predicts every read on every cycle.
module tb_regfile_2r1w;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] a_byp, b_byp, a_nob, b_nob;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [32];
    bit          model_valid = 0;

    regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut_byp (
        .clock            (clk),
        .reset            (reset),
        .ctrl_writeEnable (we),
        .ctrl_writeReg    (waddr),
        .data_writeReg    (wdata),
        .ctrl_readRegA    (ra),
        .ctrl_readRegB    (rb),
        .data_readRegA    (a_byp),
        .data_readRegB    (b_byp)
    );

    regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_dut_nob (
        .clock            (clk),
        .reset            (reset),
        .ctrl_writeEnable (we),
        .ctrl_writeReg    (waddr),
        .data_writeReg    (wdata),
        .ctrl_readRegA    (ra),
        .ctrl_readRegB    (rb),
        .data_readRegA    (a_nob),
        .data_readRegB    (b_nob)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural read: zero register, then forwarding, then stored value.
    function automatic logic [31:0] model_read(input logic [4:0] addr, input bit byp);
        if (addr == 5'd0) return 32'h0;
        if (byp && we && !reset && waddr == addr) return wdata;
        return mem[addr];
    endfunction

    // Model state update on each rising edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'h0;
            model_valid = 1;
        end else if (we && waddr != 5'd0) begin
            mem[waddr] = wdata;
        end
    end

    // Continuous comparison on the falling edge, once the model is anchored by a reset.
    always @(negedge clk) begin
        if (model_valid) begin
            check("cmp_a_byp", a_byp, model_read(ra, 1'b1));
            check("cmp_b_byp", b_byp, model_read(rb, 1'b1));
            check("cmp_a_nob", a_nob, model_read(ra, 1'b0));
            check("cmp_b_nob", b_nob, model_read(rb, 1'b0));
        end
    end

    // Apply one cycle's inputs shortly after the rising edge.
    task automatic drive(input logic rst, input logic we_i, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] a, input logic [4:0] b);
        @(posedge clk);
        #1;
        reset = rst; we = we_i; waddr = wa; wdata = wd; ra = a; rb = b;
        #1;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; ra = '0; rb = '0;

        // 1. One reset cycle, then every address reads zero on both ports.
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            check("reset_a", a_byp, 32'h0);
            check("reset_b", b_nob, 32'h0);
        end

        // 2. Write r5, then read it back on both ports; neighbours stay zero.
        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
        check("r5_same_cycle_byp", a_byp, 32'hDEADBEEF);
        check("r5_same_cycle_nob", a_nob, 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        check("r5_a_byp", a_byp, 32'hDEADBEEF);
        check("r5_b_nob", b_nob, 32'hDEADBEEF);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd6);
        check("r4_zero", a_byp, 32'h0);
        check("r6_zero", b_byp, 32'h0);

        // 3. Writes to r0 are ignored, including the forward path.
        drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        check("r0_bypass_a", a_byp, 32'h0);
        check("r0_bypass_b", b_byp, 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        check("r0_after", a_byp, 32'h0);
        check("r0_after_nob", a_nob, 32'h0);

        // 4. Forwarding on port A only; port B sees the stored r3.
        drive(1'b0, 1'b1, 5'd3,  32'h33333333, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd17, 32'h17171717, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd17, 32'h12345678, 5'd17, 5'd3);
        check("byp_a_hit",  a_byp, 32'h12345678);
        check("byp_b_miss", b_byp, 32'h33333333);
        check("nob_a_old",  a_nob, 32'h17171717);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 5'd17);
        check("nob_a_next", a_nob, 32'h12345678);
        check("byp_b_next", b_byp, 32'h12345678);

        // 5. Fill r1..r31, then reset alongside a write to r9.
        for (int k = 1; k < 32; k++) begin
            drive(1'b0, 1'b1, 5'(k), 32'(k) * 32'h01010101, 5'd0, 5'd0);
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd31);
        check("fill_r9",  a_byp, 32'h09090909);
        check("fill_r31", b_nob, 32'h1F1F1F1F);
        drive(1'b1, 1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9);
        check("rst_no_bypass", a_byp, 32'h09090909);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        check("rst_r9_byp", a_byp, 32'h0);
        check("rst_r9_nob", b_nob, 32'h0);
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i));
            check("rst_all", a_nob, 32'h0);
        end

        // 6. Back-to-back writes to r31, then an idle cycle with random address/data.
        drive(1'b0, 1'b1, 5'd30, 32'h30303030, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd1,  32'h00000011, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd31, 32'h00000001, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd31, 32'h00000002, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 5'($urandom_range(0, 31)), $urandom, 5'd31, 5'd30);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd1);
        check("r31_last",  a_byp, 32'h00000002);
        check("r1_intact", b_nob, 32'h00000011);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
        end

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regfile_2r1w
